// File: rtl/led_step_ctrl.sv
// Key debouncer and step-strobe generator for the 4-bit LED rotator.
// Optional build macro KEY_REPEAT_EN adds auto-repeat on the speed key (key0).
module led_step_ctrl #(
  parameter logic [19:0] DEB_MAX  = 20'd999_999,
  parameter logic [24:0] BASE_MAX = 25'd24_999_999
`ifdef KEY_REPEAT_EN
  ,
  parameter logic [24:0] HOLD_MAX = 25'd24_999_999
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_n,
  output logic       step,
  output logic       dir,
  output logic       run,
  output logic [1:0] speed
);

  typedef enum logic [1:0] {
    REL   = 2'd0,
    PWAIT = 2'd1,
    PRS   = 2'd2,
    RWAIT = 2'd3
  } deb_state_t;

  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  press_evt;
  logic        spd_evt;
  logic        run_nxt;
  logic [24:0] lim;
  logic [24:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // One debounce FSM per key; the state is left visible as g_key[i].state.
  for (genvar g = 0; g < 3; g++) begin : g_key
    deb_state_t  state;
    logic [19:0] dcnt;
    logic        evt;

    // dcnt holds the number of consecutive samples already seen at the pending level.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= REL;
        dcnt  <= 20'd0;
        evt   <= 1'b0;
      end else begin
        evt <= 1'b0;
        case (state)
          REL: begin
            if (!sync2[g]) begin
              state <= PWAIT;
              dcnt  <= 20'd1;
            end
          end
          PWAIT: begin
            if (sync2[g]) begin
              state <= REL;
              dcnt  <= 20'd0;
            end else if (dcnt >= DEB_MAX) begin
              state <= PRS;
              dcnt  <= 20'd0;
              evt   <= 1'b1;
            end else begin
              dcnt <= dcnt + 20'd1;
            end
          end
          PRS: begin
            if (sync2[g]) begin
              state <= RWAIT;
              dcnt  <= 20'd1;
            end
          end
          RWAIT: begin
            if (!sync2[g]) begin
              state <= PRS;
              dcnt  <= 20'd0;
            end else if (dcnt >= DEB_MAX) begin
              state <= REL;
              dcnt  <= 20'd0;
            end else begin
              dcnt <= dcnt + 20'd1;
            end
          end
          default: begin
            state <= REL;
            dcnt  <= 20'd0;
          end
        endcase
      end
    end

    assign press_evt[g] = evt;
  end

`ifdef KEY_REPEAT_EN
  logic [24:0] rep_cnt;
  logic        rep_evt;

  // Counter stays at zero outside PRS, so it restarts on every entry to PRS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt <= 25'd0;
      rep_evt <= 1'b0;
    end else begin
      rep_evt <= 1'b0;
      if (g_key[0].state != PRS) begin
        rep_cnt <= 25'd0;
      end else if (rep_cnt >= HOLD_MAX) begin
        rep_cnt <= 25'd0;
        rep_evt <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + 25'd1;
      end
    end
  end

  assign spd_evt = press_evt[0] | rep_evt;
`else
  assign spd_evt = press_evt[0];
`endif

  // The divider follows the run value being registered this cycle so that
  // step can never be high alongside run=0.
  assign run_nxt = press_evt[2] ? ~run : run;
  assign lim     = BASE_MAX >> speed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      speed <= 2'd0;
      dir   <= 1'b0;
      run   <= 1'b1;
      step  <= 1'b0;
      cnt   <= 25'd0;
    end else begin
      dir <= dir ^ press_evt[1];
      run <= run_nxt;
      if (spd_evt) begin
        speed <= speed + 2'd1;
        cnt   <= 25'd0;
        step  <= 1'b0;
      end else if (!run_nxt) begin
        step <= 1'b0;
      end else if (cnt >= lim) begin
        cnt  <= 25'd0;
        step <= (cnt == lim);
      end else begin
        cnt  <= cnt + 25'd1;
        step <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed bench for led_step_ctrl: debounce latency, step periods, pause/resume, reset.
module tb_led_step_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] key_n = 3'b111;
  logic       step;
  logic       dir;
  logic       run;
  logic [1:0] speed;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  int exp_speed = 0;

  always #5 clk = ~clk;

  led_step_ctrl #(
    .DEB_MAX(20'd4),
    .BASE_MAX(25'd15)
`ifdef KEY_REPEAT_EN
    , .HOLD_MAX(25'd31)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_n(key_n),
    .step(step),
    .dir(dir),
    .run(run),
    .speed(speed)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=%0d expected=<nothing queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  // Negedges until the next step pulse; 999 if none arrives.
  task automatic next_step(output int gap);
    gap = 0;
    do begin
      tick(1);
      gap++;
    end while (step !== 1'b1 && gap < 100);
    if (step !== 1'b1) gap = 999;
  endtask

  // Drive keys low and count negedges until speed/dir/run changes; 999 on timeout.
  task automatic press(input logic [2:0] mask, output int lat);
    logic [3:0] snap;
    snap  = {speed, dir, run};
    key_n = key_n & ~mask;
    lat   = 0;
    do begin
      tick(1);
      lat++;
    end while ({speed, dir, run} === snap && lat < 60);
    if ({speed, dir, run} === snap) lat = 999;
  endtask

  task automatic release_keys();
    key_n = 3'b111;
    tick(12);
  endtask

  function automatic int lim_of(input int s);
    return 15 >> s;
  endfunction

  task automatic speed_press();
    int lat;
    int g;
    exp_speed = (exp_speed + 1) % 4;
    exp_q.push_back(32'd8);
    exp_q.push_back(32'(exp_speed));
    repeat (3) exp_q.push_back(32'(lim_of(exp_speed) + 1));
    press(3'b001, lat);
    pop_check("spd_latency", lat);
    pop_check("spd_value", speed);
    next_step(g);
    pop_check("spd_first_gap", g);
    release_keys();
    next_step(g);
    next_step(g);
    pop_check("spd_period_a", g);
    next_step(g);
    pop_check("spd_period_b", g);
  endtask

  initial begin
    int g;
    int lat;
    int steps;
    int held;

    // 1: reset values, then period 16 at speed 0
    tick(10);
    check("rst_speed", speed, 0);
    check("rst_dir", dir, 0);
    check("rst_run", run, 1);
    check("rst_step", step, 0);
    rst = 1'b1;
    repeat (3) exp_q.push_back(32'd16);
    repeat (3) begin
      next_step(g);
      pop_check("base_period", g);
    end

    // 2: bounce rejected, then a clean press
    key_n[0] = 1'b0;
    tick(3);
    key_n[0] = 1'b1;
    tick(15);
    check("bounce_speed", speed, 0);
    speed_press();

    // 3: four more presses cycle through 2, 3, 0, 1
    repeat (4) speed_press();
    check("spd_dir_kept", dir, 0);
    check("spd_run_kept", run, 1);

    // 4: pause two cycles after a step, resume from the held count
    next_step(g);
    tick(2);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd0);
    press(3'b100, lat);
    pop_check("pause_latency", lat);
    pop_check("pause_run", run);
    release_keys();
    steps = 0;
    repeat (200) begin
      tick(1);
      if (step === 1'b1) steps++;
    end
    check("pause_no_step", steps, 0);
    held = (2 + 8 - 1) % (lim_of(exp_speed) + 1);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'(lim_of(exp_speed) - held));
    exp_q.push_back(32'(lim_of(exp_speed) + 1));
    press(3'b100, lat);
    pop_check("resume_latency", lat);
    pop_check("resume_run", run);
    next_step(g);
    pop_check("resume_gap", g);
    next_step(g);
    pop_check("resume_period", g);
    release_keys();

    // 5: key1 and key2 together toggle dir and run on the same edge
    press(3'b110, lat);
    check("dual_latency", lat, 8);
    check("dual_dir", dir, 1);
    check("dual_run", run, 0);
    check("dual_speed", speed, 32'(exp_speed));
    release_keys();

    // 6: reset during debounce, key still held through release
    key_n[0] = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(3);
    check("rst2_speed", speed, 0);
    check("rst2_dir", dir, 0);
    check("rst2_run", run, 1);
    check("rst2_step", step, 0);
    rst = 1'b1;
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (speed === 2'd0 && lat < 60);
    if (speed === 2'd0) lat = 999;
    check("rst2_latency", lat, 8);
    check("rst2_speed_one", speed, 1);
`ifdef KEY_REPEAT_EN
    for (int k = 0; k < 3; k++) begin
      logic [1:0] before;
      before = speed;
      lat = 0;
      do begin
        tick(1);
        lat++;
      end while (speed === before && lat < 60);
      if (speed === before) lat = 999;
      check("repeat_gap", lat, 32);
      check("repeat_speed", speed, 32'((k + 2) % 4));
    end
`else
    tick(100);
    check("held_single_press", speed, 1);
`endif
    release_keys();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
